// File: rtl/p2s_shifter.sv
// Parallel-to-serial transmitter with bit-rate prescaler, serial clock and start/busy/done handshake.
// Define P2S_RX_EN to shift s_in into the vacated bits and expose the received word on rx_data.
module p2s_shifter #(
  parameter int WIDTH = 9,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] p_in,
  input  logic             lsb_first,
  input  logic             s_in,
  output logic             s_out,
  output logic             s_clk,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rx_data
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = $clog2(DIV);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             lsb_q, lsb_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [CW-1:0]    bit_q, bit_d;
  logic             fill_bit;

`ifdef P2S_RX_EN
  assign fill_bit = s_in;
`else
  logic unused_s_in;
  assign unused_s_in = s_in;
  assign fill_bit    = 1'b0;
`endif

  always_comb begin
    // NOTE: every variable gets a default here so no path leaves one unassigned (no latches).
    state_d = state_q;
    sreg_d  = sreg_q;
    lsb_d   = lsb_q;
    presc_d = presc_q;
    bit_d   = bit_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SHIFT;
          sreg_d  = p_in;
          lsb_d   = lsb_first;
          presc_d = '0;
          bit_d   = '0;
        end
      end
      ST_SHIFT: begin
        if (presc_q == PW'(DIV - 1)) begin
          presc_d = '0;
          bit_d   = bit_q + 1'b1;
          sreg_d  = lsb_q ? {fill_bit, sreg_q[WIDTH-1:1]}
                          : {sreg_q[WIDTH-2:0], fill_bit};
          if (bit_q == CW'(WIDTH - 1)) state_d = ST_DONE;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; the shift register is
  // reset too, because rx_data and s_out expose it directly after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      lsb_q   <= 1'b0;
      presc_q <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      lsb_q   <= lsb_d;
      presc_q <= presc_d;
      bit_q   <= bit_d;
    end
  end

  assign busy  = (state_q == ST_SHIFT);
  assign done  = (state_q == ST_DONE);
  assign s_out = busy & (lsb_q ? sreg_q[0] : sreg_q[WIDTH-1]);
  assign s_clk = busy & (presc_q >= PW'(DIV / 2));

`ifdef P2S_RX_EN
  assign rx_data = busy ? '0 : sreg_q;
`else
  assign rx_data = '0;
`endif

endmodule

// File: tb/tb_p2s_shifter.sv
// Directed self-checking bench for p2s_shifter (WIDTH=9, DIV=4); honours P2S_RX_EN for loopback expectations.
module tb_p2s_shifter;

  localparam int WIDTH = 9;
  localparam int DIV   = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             lsb_first = 1'b0;
  logic             loop_en = 1'b0;
  logic [WIDTH-1:0] p_in = '0;
  logic             s_in;
  logic             s_out, s_clk, busy, done;
  logic [WIDTH-1:0] rx_data;

  int checks = 0;
  int errors = 0;

  assign s_in = loop_en & s_out;

  always #5 clk = ~clk;

  p2s_shifter #(.WIDTH(WIDTH), .DIV(DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .p_in      (p_in),
    .lsb_first (lsb_first),
    .s_in      (s_in),
    .s_out     (s_out),
    .s_clk     (s_clk),
    .busy      (busy),
    .done      (done),
    .rx_data   (rx_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " busy"},    32'(busy),    32'd0);
    check({tag, " done"},    32'(done),    32'd0);
    check({tag, " s_out"},   32'(s_out),   32'd0);
    check({tag, " s_clk"},   32'(s_clk),   32'd0);
    check({tag, " rx_data"}, 32'(rx_data), 32'd0);
  endtask

  // seq holds the expected serial stream, first bit in seq[8].
  task automatic run_tx(input logic [8:0] word, input logic lsb, input logic [8:0] seq,
                        input logic [8:0] exp_rx, input string tag);
    int   rises = 0;
    logic prev_clk = 1'b0;
    logic exp_bit;
    p_in      = word;
    lsb_first = lsb;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < WIDTH * DIV; c++) begin
      exp_bit = seq[8 - c / DIV];
      check({tag, " busy"},    32'(busy),    32'd1);
      check({tag, " s_out"},   32'(s_out),   32'(exp_bit));
      check({tag, " s_clk"},   32'(s_clk),   32'((c % DIV) >= DIV / 2));
      check({tag, " done"},    32'(done),    32'd0);
      check({tag, " rx_busy"}, 32'(rx_data), 32'd0);
      if (s_clk && !prev_clk) rises++;
      prev_clk = s_clk;
      tick();
    end
    check({tag, " done pulse"},  32'(done),    32'd1);
    check({tag, " busy end"},    32'(busy),    32'd0);
    check({tag, " s_out end"},   32'(s_out),   32'd0);
    check({tag, " s_clk end"},   32'(s_clk),   32'd0);
    check({tag, " rx_data"},     32'(rx_data), 32'(exp_rx));
    check({tag, " s_clk rises"}, 32'(rises),   32'd9);
    tick();
    check({tag, " done clear"},  32'(done),    32'd0);
    check({tag, " busy idle"},   32'(busy),    32'd0);
  endtask

  initial begin
    int          starts = 0;
    int          dones = 0;
    int          cyc = 0;
    logic [8:0]  cur = '0;
    logic [8:0]  last_pin = '0;
    logic        prev_busy = 1'b0;
    logic [8:0]  loop_rx;

`ifdef P2S_RX_EN
    loop_rx = 9'h0F3;
`else
    loop_rx = 9'h000;
`endif

    // Reset state
    tick();
    tick();
    check_idle_outputs("reset");
    rst_n = 1'b1;

    // Reset mid-transfer: abort while s_out and s_clk are both high
    p_in  = 9'h1FF;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    check("pre-reset s_out", 32'(s_out), 32'd1);
    check("pre-reset s_clk", 32'(s_clk), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async reset");
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    check_idle_outputs("reset released");
    run_tx(9'h1A5, 1'b0, 9'b110100101, 9'h000, "post-reset");

    // Bit-order variants
    run_tx(9'h1A5, 1'b0, 9'b110100101, 9'h000, "msb");
    run_tx(9'h1A5, 1'b1, 9'b101001011, 9'h000, "lsb");

    // Loopback: s_in follows s_out
    loop_en = 1'b1;
    run_tx(9'h0F3, 1'b0, 9'b011110011, loop_rx, "loop");
    loop_en = 1'b0;

    // start held high with p_in changing every cycle
    start = 1'b1;
    for (int i = 0; i < 125; i++) begin
      if (i == 80) start = 1'b0;
      last_pin = 9'(i * 53 + 7);
      p_in     = last_pin;
      tick();
      if (busy && !prev_busy) begin
        starts++;
        cur = last_pin;
        cyc = 0;
      end
      if (busy) begin
        if (cyc < WIDTH * DIV) check("held s_out", 32'(s_out), 32'(cur[8 - cyc / DIV]));
        else                   check("held busy length", 32'(cyc), 32'(WIDTH * DIV - 1));
        cyc++;
      end
      if (done) begin
        dones++;
        check("held done cycles", 32'(cyc), 32'(WIDTH * DIV));
      end
      prev_busy = busy;
    end
    check("held starts", 32'(starts), 32'd3);
    check("held dones",  32'(dones),  32'd3);
    check_idle_outputs("final idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/p2s_shifter.md
# p2s_shifter

Parametrised parallel-to-serial transmitter with built-in bit-rate prescaler, serial clock generation and start/busy/done handshake. A parallel word is accepted on `start`, then shifted out one bit per bit period, MSB-first or LSB-first, selected per transfer. The block sits between display/peripheral logic and an external serial shift chain (e.g. a '164-style LED driver) and replaces fixed-width serial/parallel-load shift registers in P2S paths.

## Interface
- `WIDTH`, 9: bits per transfer; legal range 2..32.
- `DIV`, 4: `clk` cycles per serial bit; even, at least 2.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: transfer request; sampled only in IDLE.
- `p_in` input WIDTH: parallel word; captured on an accepted `start`.
- `lsb_first` input 1: bit-order select; captured with `p_in`. 0 = MSB-first, 1 = LSB-first.
- `s_in` input 1: serial return data, used only when `P2S_RX_EN` is defined.
- `s_out` output 1: serial data; always the current head bit of the shift register.
- `s_clk` output 1: serial clock; rising edge at the middle of each bit period.
- `busy` output 1: high while a transfer is in progress.
- `done` output 1: one-cycle pulse after the last bit.
- `rx_data` output WIDTH: received word; valid from `done` until the next accepted `start`.

## Operation
- **States:**
  - **IDLE:** `busy`=0.
  - **SHIFT:** `busy`=1.
  - **DONE:** one cycle, `done`=1, `busy`=0.
- **IDLE → SHIFT:** on an edge with `start`=1.
  - Load `sreg` from `p_in` and latch `lsb_first`.
  - Clear the prescaler and set the bit counter to 0.
- **Start while not IDLE:** `start`=1 in SHIFT or DONE is ignored. There is no queueing.
- **Bit period:** the prescaler counts 0..DIV-1 during SHIFT.
  - `s_clk` = 0 while prescaler < DIV/2, and 1 otherwise.
- **End of each bit period** (prescaler = DIV-1):
  - MSB-first: `sreg` shifts left and the vacated bit 0 takes the fill bit.
  - LSB-first: `sreg` shifts right and the vacated bit WIDTH-1 takes the fill bit.
  - The bit counter increments.
- **Head bit:**
  - MSB-first: `s_out` = `sreg[WIDTH-1]`.
  - LSB-first: `s_out` = `sreg[0]`.
- **SHIFT → DONE:** at the end of bit period WIDTH-1. DONE → IDLE always follows.
- **`rx_data`:** equals `sreg` in DONE and IDLE, and reads 0 during SHIFT.
- **Outside SHIFT:** `s_clk` = 0 and `s_out` = 0.
- **Counter widths:** the bit counter is $clog2(WIDTH+1) bits and the prescaler is $clog2(DIV) bits. Neither wraps within a transfer.
- **Reset** (at any time, including mid-transfer):
  - The transfer is aborted immediately and the state returns to IDLE.
  - `sreg` = 0, `busy` = 0, `done` = 0, `s_out` = 0, `s_clk` = 0, `rx_data` = 0.
  - The first `start` is accepted on the first rising edge after `rst_n` deasserts.

## Timing
- **Accept:** `start` is sampled at edge k.
  - `busy`=1 and the first head bit is on `s_out` from edge k+1.
- **Bit duration:** each bit is stable on `s_out` for exactly DIV cycles.
- **`s_clk`:** rises DIV/2 cycles into each bit period, giving DIV/2 cycles of setup and hold around the rising edge.
- **Transfer length:** `busy` stays high for exactly WIDTH×DIV cycles, from edge k+1 to edge k+1+WIDTH×DIV.
- **Done:** `done` is high for the single cycle that starts at edge k+1+WIDTH×DIV.
- **Earliest next start:** a new `start` can first be accepted at edge k+2+WIDTH×DIV. The minimum start-to-start interval is WIDTH×DIV+2 cycles.
- **`s_in` sampling:** `s_in` is sampled on the shift edge (end of each bit period).

## Configuration
- **Macro:** `P2S_RX_EN`.
- **Defined:**
  - The fill bit is `s_in` sampled at the shift edge.
  - After a transfer, `rx_data` holds the WIDTH bits received, in the same bit order as transmitted.
- **Undefined:**
  - The fill bit is 0 and `s_in` is ignored.
  - `rx_data` is constant 0.
  - All transmit timing is identical in both builds.

## Test plan
All scenarios use WIDTH=9, DIV=4.
- **Reset mid-transfer:** assert `rst_n`=0 during SHIFT and release it after 3 cycles.
  - `busy`, `done`, `s_out` and `s_clk` are 0 asynchronously.
  - A new `start` after release transmits correctly from its first bit.
- **MSB-first transmit:** `p_in`=9'h1A5, `lsb_first`=0, 1-cycle `start`.
  - `s_out` shows 1,1,0,1,0,0,1,0,1, each bit for 4 cycles.
  - `s_clk` makes 9 rising edges.
  - `busy`=1 for 36 cycles, then `done` pulses once.
- **LSB-first transmit:** `p_in`=9'h1A5, `lsb_first`=1.
  - `s_out` shows 1,0,1,0,0,1,0,1,1.
  - Timing is identical to the MSB-first case.
- **Start ignored while busy:** hold `start`=1 continuously with `p_in` changing every cycle.
  - Only the word present at the accept edge is sent.
  - Transfers restart every 38 cycles.
  - `done` pulses once per transfer.
- **Loopback with `P2S_RX_EN`:** `s_in` tied to `s_out`, `p_in`=9'h0F3, MSB-first.
  - At `done`, `rx_data`=9'h0F3.
  - Without the macro, `rx_data`=0 and the `s_out` stream is unchanged.
